r5_out_serializer: RTL and testbench
====================================

Name: r5_out_serializer

Overview:
- Consumer end of the radix-5 butterfly pipeline-register stages.
- Accepts one 5-point complex result bundle (all points in parallel) with a valid/ready handshake.
- Emits the bundle one complex point per cycle on a streaming valid/ready interface, feeding the output store / next FFT stage.
- Supports back-to-back bundles with no bubble between bursts.

Parameters:
- DW, 32, width of each real/imag word (two's complement).
- NPTS, 5, points per bundle (radix).
- IW, 3, width of point index; must satisfy 2^IW >= NPTS.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  bundle present on in_re/in_img
- in_ready  out  1  block can accept a bundle this cycle
- in_re  in  NPTS*DW  real parts; point k at bits [k*DW +: DW]
- in_img  in  NPTS*DW  imag parts, same packing
- out_valid  out  1  out_re/out_img/out_idx valid
- out_ready  in  1  downstream accepts the point this cycle
- out_re  out  DW  real part of current point
- out_img  out  DW  imag part of current point
- out_idx  out  IW  index k of current point, 0..NPTS-1
- out_last  out  1  high with point NPTS-1
- busy  out  1  high in SEND state

Behaviour:
- Reset (async assert; release takes effect on the next clk edge):
  - state=IDLE, idx=0, hold regs=0.
  - out_valid=0, out_re=0, out_img=0, out_idx=0, out_last=0, busy=0.
- States:
  - IDLE: in_ready=1, out_valid=0. On in_valid, capture in_re/in_img into the hold register, set idx=0, go to SEND.
  - SEND: out_valid=1. Outputs are the registered hold[idx].
    - out_ready=1 and idx<NPTS-1: idx increments.
    - out_ready=1 and idx=NPTS-1 (last handshake): if in_valid, capture the new bundle, set idx=0, stay in SEND (zero-bubble); otherwise go to IDLE.
    - out_ready=0: idx and outputs hold stable. Outputs must not change while out_valid=1 and out_ready=0.
- in_ready = (state==IDLE) OR (state==SEND AND idx==NPTS-1 AND out_ready). This is combinational from state, idx and out_ready only; no path from in_valid.
- Latency: bundle accepted at edge t gives point 0 at out_valid from t+1. A bundle occupies exactly NPTS output handshakes.
- out_last = out_valid AND (idx==NPTS-1).
- in_valid while in_ready=0: ignored; the upstream holds the bundle.
- Reset mid-burst: the remaining points are discarded and no partial output is produced after release.
- Index never exceeds NPTS-1; it wraps to 0 only on a new capture.
- No arithmetic on data except under the optional feature.

Optional Feature:
- Macro: R5_SER_CONJ_EN.
- When defined: out_img is the two's-complement negation of hold_img[idx], giving a conjugated output for IFFT reuse. The most-negative value -2^(DW-1) saturates to 2^(DW-1)-1. out_re is unchanged.
- When undefined: out_img = hold_img[idx] unmodified, and no negation logic is synthesized.

Decomposition:
- Package r5_pkg:
  - localparams DW=32, NPTS=5, IW=3.
  - state enum {IDLE, SEND}.
  - Constants DMAX=2^(DW-1)-1 and DMIN=-2^(DW-1) for saturation.
- Sub-module r5_ser_hold: bundle holding register (load enable, async reset) with indexed read mux output. The top block contains the FSM, index counter and handshake logic.

Test Plan:
- Reset, then in_valid=1 with bundle re[k]=k+1, img[k]=-(k+1), out_ready=1 always → in_ready=1; out points (1,-1)..(5,-5) on 5 consecutive cycles, out_idx 0..4, out_last only at idx 4, then out_valid=0.
- Two bundles presented back-to-back (second in_valid held), out_ready=1 → 10 consecutive out_valid cycles with no gap; second bundle captured on the idx=4 handshake.
- Bundle in flight, out_ready toggled 1,0,0,1,... → out_idx and data stable during out_ready=0; all 5 points delivered in order, none duplicated or skipped.
- Assert rst while out_idx=2 → out_valid, out_re, out_img, out_idx go to 0 immediately; after release in_ready=1 and the next bundle starts at idx 0.
- in_valid=1 during SEND with idx<4 → in_ready=0; bundle not captured until the idx=4 handshake.
- With R5_SER_CONJ_EN defined, img[0]=0x80000000 and img[1]=0x00000005 → out_img = 0x7FFFFFFF and 0xFFFFFFFB; with the macro undefined, the same values pass through unchanged.

Source files
------------

// File: rtl/r5_pkg.sv
// Shared constants, state encoding and the optional conjugation helper for the
// radix-5 output serializer. Helper exists only when R5_SER_CONJ_EN is defined.
package r5_pkg;

   localparam int DW   = 32;
   localparam int NPTS = 5;
   localparam int IW   = 3;

   localparam logic [IW-1:0] LAST_IDX = IW'(NPTS - 1);

   localparam logic [DW-1:0] DMAX = {1'b0, {(DW-1){1'b1}}};
   localparam logic [DW-1:0] DMIN = {1'b1, {(DW-1){1'b0}}};

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

`ifdef R5_SER_CONJ_EN
   // Negation with the one unrepresentable case clamped to the positive rail.
   function automatic logic [DW-1:0] conj_sat(input logic [DW-1:0] v);
      logic [DW-1:0] r;
      if (v == DMIN) begin
         r = DMAX;
      end else begin
         r = ~v + {{(DW-1){1'b0}}, 1'b1};
      end
      return r;
   endfunction
`endif

endpackage

// File: rtl/r5_ser_hold.sv
// Bundle holding register for the radix-5 serializer: loads all NPTS points at
// once and exposes one of them through an index-selected read mux.
module r5_ser_hold
   import r5_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic [NPTS*DW-1:0]   in_re,
   input  logic [NPTS*DW-1:0]   in_img,
   input  logic [IW-1:0]        rd_idx,
   output logic [DW-1:0]        rd_re,
   output logic [DW-1:0]        rd_img
);

   logic [NPTS*DW-1:0] hold_re;
   logic [NPTS*DW-1:0] hold_img;

   // Whole-bundle capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_re  <= {(NPTS*DW){1'b0}};
         hold_img <= {(NPTS*DW){1'b0}};
      end else if (load) begin
         hold_re  <= in_re;
         hold_img <= in_img;
      end else begin
         hold_re  <= hold_re;
         hold_img <= hold_img;
      end
   end

   // Out-of-range indices read as zero.
   always_comb begin
      rd_re  = {DW{1'b0}};
      rd_img = {DW{1'b0}};
      for (int k = 0; k < NPTS; k++) begin
         if (rd_idx == IW'(k)) begin
            rd_re  = hold_re[k*DW +: DW];
            rd_img = hold_img[k*DW +: DW];
         end else begin
            rd_re  = rd_re;
            rd_img = rd_img;
         end
      end
   end

endmodule

// File: rtl/r5_out_serializer.sv
// Radix-5 output serializer: takes a parallel 5-point bundle and streams it one
// point per cycle. Define R5_SER_CONJ_EN to emit the saturated conjugate on out_img.
module r5_out_serializer
   import r5_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [NPTS*DW-1:0]   in_re,
   input  logic [NPTS*DW-1:0]   in_img,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DW-1:0]        out_re,
   output logic [DW-1:0]        out_img,
   output logic [IW-1:0]        out_idx,
   output logic                 out_last,
   output logic                 busy
);

   state_t        state;
   state_t        state_next;
   logic [IW-1:0] idx;
   logic [IW-1:0] idx_next;
   logic          capture;
   logic          advance;
   logic [DW-1:0] rd_re;
   logic [DW-1:0] rd_img;
   logic [DW-1:0] pt_re;
   logic [DW-1:0] img_src;
   logic [DW-1:0] pt_img;

   // The read mux looks ahead at the next index so output registers load it directly.
   r5_ser_hold u_hold (
      .clk    (clk),
      .rst    (rst),
      .load   (capture),
      .in_re  (in_re),
      .in_img (in_img),
      .rd_idx (idx_next),
      .rd_re  (rd_re),
      .rd_img (rd_img)
   );

   // in_ready depends on registered state and out_ready only, never on in_valid.
   assign in_ready  = (state == IDLE) ||
                      ((state == SEND) && (idx == LAST_IDX) && out_ready);
   assign out_valid = (state == SEND);
   assign busy      = (state == SEND);
   assign out_idx   = idx;
   assign out_last  = (state == SEND) && (idx == LAST_IDX);

   // State and index registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         idx   <= {IW{1'b0}};
      end else begin
         state <= state_next;
         idx   <= idx_next;
      end
   end

   // Next-state, index advance and capture decisions.
   always_comb begin
      state_next = state;
      idx_next   = idx;
      capture    = 1'b0;
      advance    = 1'b0;
      case (state)
         IDLE: begin
            if (in_valid) begin
               capture    = 1'b1;
               state_next = SEND;
               idx_next   = {IW{1'b0}};
            end else begin
               state_next = IDLE;
            end
         end
         SEND: begin
            if (out_ready) begin
               if (idx == LAST_IDX) begin
                  if (in_valid) begin
                     capture  = 1'b1;
                     idx_next = {IW{1'b0}};
                  end else begin
                     state_next = IDLE;
                     idx_next   = {IW{1'b0}};
                  end
               end else begin
                  advance  = 1'b1;
                  idx_next = idx + IW'(1'b1);
               end
            end else begin
               state_next = SEND;
            end
         end
         default: begin
            state_next = IDLE;
            idx_next   = {IW{1'b0}};
         end
      endcase
   end

   // On capture the hold register is not yet loaded, so point 0 bypasses it.
   always_comb begin
      pt_re   = rd_re;
      img_src = rd_img;
      if (capture) begin
         pt_re   = in_re[DW-1:0];
         img_src = in_img[DW-1:0];
      end else begin
         pt_re   = rd_re;
         img_src = rd_img;
      end
   end

`ifdef R5_SER_CONJ_EN
   assign pt_img = conj_sat(img_src);
`else
   assign pt_img = img_src;
`endif

   // Output data registers; they only move on a capture or an accepted point.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_re  <= {DW{1'b0}};
         out_img <= {DW{1'b0}};
      end else if (capture || advance) begin
         out_re  <= pt_re;
         out_img <= pt_img;
      end else begin
         out_re  <= out_re;
         out_img <= out_img;
      end
   end

endmodule

// File: tb/tb_r5_out_serializer.sv
// Self-checking bench for r5_out_serializer: a queue-based reference model of
// bundles in and points out, driven by directed and randomized steps.
module tb_r5_out_serializer;

   localparam int DW   = 32;
   localparam int NPTS = 5;
   localparam int IW   = 3;

   typedef struct {
      logic [DW-1:0] re;
      logic [DW-1:0] img;
      logic [IW-1:0] idx;
   } pt_t;

   logic                clk = 1'b0;
   logic                rst;
   logic                in_valid;
   logic                in_ready;
   logic [NPTS*DW-1:0]  in_re;
   logic [NPTS*DW-1:0]  in_img;
   logic                out_valid;
   logic                out_ready;
   logic [DW-1:0]       out_re;
   logic [DW-1:0]       out_img;
   logic [IW-1:0]       out_idx;
   logic                out_last;
   logic                busy;

   int errors = 0;
   int checks = 0;
   int vcount = 0;

   logic [NPTS*DW-1:0] up_re_q[$];
   logic [NPTS*DW-1:0] up_img_q[$];
   pt_t                exp_q[$];

   r5_out_serializer dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_re     (in_re),
      .in_img    (in_img),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_re    (out_re),
      .out_img   (out_img),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] exp_img(input logic [DW-1:0] v);
`ifdef R5_SER_CONJ_EN
      if (v == 32'h8000_0000) return 32'h7FFF_FFFF;
      return 32'h0000_0000 - v;
`else
      return v;
`endif
   endfunction

   task automatic push_bundle(input logic [NPTS*DW-1:0] r, input logic [NPTS*DW-1:0] i);
      up_re_q.push_back(r);
      up_img_q.push_back(i);
   endtask

   task automatic push_random();
      logic [NPTS*DW-1:0] r;
      logic [NPTS*DW-1:0] i;
      for (int k = 0; k < NPTS; k++) begin
         r[k*DW +: DW] = $urandom;
         i[k*DW +: DW] = $urandom;
      end
      push_bundle(r, i);
   endtask

   // One cycle: drive at negedge, check against the model, then update the model.
   task automatic step(input logic ordy);
      logic exp_rdy;
      logic accept;
      pt_t  p;
      logic [NPTS*DW-1:0] br;
      logic [NPTS*DW-1:0] bi;
      @(negedge clk);
      out_ready = ordy;
      in_valid  = (up_re_q.size() != 0);
      if (in_valid) begin
         in_re  = up_re_q[0];
         in_img = up_img_q[0];
      end else begin
         for (int k = 0; k < NPTS; k++) begin
            in_re[k*DW +: DW]  = $urandom;
            in_img[k*DW +: DW] = $urandom;
         end
      end
      #1;
      exp_rdy = (exp_q.size() == 0) || ((exp_q.size() == 1) && ordy);
      chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
      chk("out_valid", {31'd0, out_valid}, {31'd0, (exp_q.size() != 0)});
      chk("busy", {31'd0, busy}, {31'd0, (exp_q.size() != 0)});
      if (out_valid === 1'b1) vcount++;
      if (exp_q.size() != 0) begin
         chk("out_re", out_re, exp_q[0].re);
         chk("out_img", out_img, exp_q[0].img);
         chk("out_idx", {29'd0, out_idx}, {29'd0, exp_q[0].idx});
         chk("out_last", {31'd0, out_last}, {31'd0, (exp_q[0].idx == 3'd4)});
         if (ordy) void'(exp_q.pop_front());
      end
      accept = in_valid && exp_rdy;
      if (accept) begin
         br = up_re_q.pop_front();
         bi = up_img_q.pop_front();
         for (int k = 0; k < NPTS; k++) begin
            p.re  = br[k*DW +: DW];
            p.img = exp_img(bi[k*DW +: DW]);
            p.idx = 3'(k);
            exp_q.push_back(p);
         end
      end
   endtask

   // mode 0: always ready, 1: pattern 1,0,0 repeating, 2: random ready.
   task automatic drain(input int mode);
      int   guard = 0;
      logic r;
      while ((exp_q.size() != 0 || up_re_q.size() != 0) && guard < 300) begin
         case (mode)
            0:       r = 1'b1;
            1:       r = ((guard % 3) == 0);
            default: r = 1'($urandom_range(0, 1));
         endcase
         step(r);
         guard++;
      end
      chk("drain_bound", {31'd0, (guard < 300)}, 32'd1);
      step(1'b1);
   endtask

   initial begin
      logic [NPTS*DW-1:0] br;
      logic [NPTS*DW-1:0] bi;
      int g;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      in_re = '0; in_img = '0;
      #12;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_re", out_re, 32'd0);
      chk("rst_out_img", out_img, 32'd0);
      chk("rst_out_idx", {29'd0, out_idx}, 32'd0);
      chk("rst_out_last", {31'd0, out_last}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk) rst = 1'b0;

      // Directed bundle re=k+1, img=-(k+1).
      for (int k = 0; k < NPTS; k++) begin
         br[k*DW +: DW] = 32'(k + 1);
         bi[k*DW +: DW] = 32'h0 - 32'(k + 1);
      end
      push_bundle(br, bi);
      vcount = 0;
      drain(0);
      chk("t1_valid_cycles", 32'(vcount), 32'd5);

      // Two bundles back-to-back, no gap expected.
      push_random(); push_random();
      vcount = 0;
      drain(0);
      chk("t2_valid_cycles", 32'(vcount), 32'd10);

      // Stalling downstream.
      push_random();
      drain(1);

      // Reset while point 2 is on the output.
      push_random();
      g = 0;
      while (!(exp_q.size() != 0 && exp_q[0].idx == 3'd2) && g < 20) begin
         step(1'b1);
         g++;
      end
      chk("t4_reach_idx2", {31'd0, (g < 20)}, 32'd1);
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b0;
      #1;
      chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("mid_rst_out_re", out_re, 32'd0);
      chk("mid_rst_out_img", out_img, 32'd0);
      chk("mid_rst_out_idx", {29'd0, out_idx}, 32'd0);
      exp_q.delete(); up_re_q.delete(); up_img_q.delete();
      @(negedge clk) rst = 1'b0;
      step(1'b1); step(1'b1);
      push_random();
      drain(0);

      // Randomized bundles with random back-pressure.
      for (int n = 0; n < 6; n++) push_random();
      drain(2);

      // Saturation / negation corner values on img.
      for (int k = 0; k < NPTS; k++) begin
         br[k*DW +: DW] = $urandom;
         bi[k*DW +: DW] = $urandom;
      end
      bi[0 +: DW]  = 32'h8000_0000;
      bi[DW +: DW] = 32'h0000_0005;
      push_bundle(br, bi);
      drain(0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
